// File: rtl/icache_fill_controller.sv
// Instruction-cache miss handler: refills one block from pipelined memory and stalls fetch until it is installed.
// Optional build macro CRITICAL_WORD_FIRST_EN: the fill starts at the missing word, wraps around, and adds critical_word_valid.
module icache_fill_controller #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8,
  localparam int OFF_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  data_word_sel,
  output logic [15:0]       fill_data,
  output logic              write_tag_array,
  output logic              fill_done
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic              critical_word_valid
`endif
);

  localparam int CNT_W  = OFF_W + 1;
  localparam int BASE_W = ADDR_W - OFF_W - 1;
  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  start_idx;
  logic [OFF_W-1:0]  issue_idx;
  logic [OFF_W-1:0]  ret_idx;
  logic              unused_addr_bits;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  off0_q, off0_d;

  assign start_idx        = off0_q;
  assign unused_addr_bits = miss_address[0];
`else
  assign start_idx        = '0;
  assign unused_addr_bits = ^miss_address[OFF_W:0];
`endif

  // Word indices are OFF_W wide, so the add wraps modulo the block size.
  assign issue_idx = issue_cnt_q[OFF_W-1:0] + start_idx;
  assign ret_idx   = ret_cnt_q[OFF_W-1:0] + start_idx;
  assign fill_data = mem_data;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      off0_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
`ifdef CRITICAL_WORD_FIRST_EN
      off0_q      <= off0_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    base_d           = base_q;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    data_word_sel    = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
    off0_d              = off0_q;
    critical_word_valid = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Stall fetch in the miss cycle itself; returns arriving here are stale and dropped.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          base_d      = miss_address[ADDR_W-1:OFF_W+1];
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = FILL;
`ifdef CRITICAL_WORD_FIRST_EN
          off0_d      = miss_address[OFF_W:1];
`endif
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        if (issue_cnt_q < BLOCK_CNT) begin
          mem_en      = 1'b1;
          mem_addr    = {base_q, issue_idx, 1'b0};
          issue_cnt_d = issue_cnt_q + 1'b1;
        end

        // Returns arrive in request order, so the return counter alone picks the target word.
        if (mem_data_valid && (ret_cnt_q < BLOCK_CNT)) begin
          write_data_array = 1'b1;
          data_word_sel    = ret_idx;
          ret_cnt_d        = ret_cnt_q + 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
          critical_word_valid = (ret_cnt_q == '0);
`endif
          if (ret_cnt_q == LAST_CNT) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_d         = IDLE;
          end
        end
      end
    endcase
  end

endmodule
